// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Asynchronous serial transmitter. Accepts one byte per handshake from the
//   frame serializer and shifts it out as: start bit, 8 data bits LSB first,
//   optional parity bit, then 1 or 2 stop bits. Also counts transmitted bytes.
//
// Parameters
//   CLOCKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY         : 0 = none, 1 = odd, 2 = even
//   STOP_BITS      : 1 or 2
//
// Ports
//   clock             : single clock, all state changes on posedge
//   reset             : asynchronous, active-low
//   uart_data         : byte to send, sampled only on the accept edge
//   uart_clock_enable : transfer request from the serializer
//   uart_ready        : high when idle and able to accept (registered)
//   tx                : serial line, idle high (registered)
//   sent_count        : number of fully transmitted bytes, wraps at 2^16
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLOCKS_PER_BIT = 104,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  uart_data,
  input  logic        uart_clock_enable,
  output logic        uart_ready,
  output logic        tx,
  output logic [15:0] sent_count
);

  if (CLOCKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_tx: illegal parameter combination");
  end

  localparam int                CYC_W     = $clog2(CLOCKS_PER_BIT);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [2:0]         bit_q, bit_d;      // data bit index in DATA, stop bit index in STOP
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               armed_q, armed_d;
  logic [15:0]        sent_count_q, sent_count_d;

  logic               accept;
  logic               tick;
  logic               parity_bit;
  logic [2:0]         bit_nxt;

  // The armed flag makes a held-high enable produce exactly one frame.
  assign accept     = (state_q == S_IDLE) && ready_q && uart_clock_enable && armed_q;
  assign tick       = (cyc_q == CYC_LAST);
  assign bit_nxt    = bit_q + 3'd1;
  assign parity_bit = (PARITY == 2) ? ^shift_q : ~^shift_q;

  // State register plus datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      ready_q      <= 1'b1;
      armed_q      <= 1'b1;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      ready_q      <= ready_d;
      armed_q      <= armed_d;
      sent_count_q <= sent_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && bit_q == 3'd7) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick && bit_q == STOP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. The tx value for the next bit is registered on
  // the same edge that ends the current bit, so tx is glitch-free.
  always_comb begin
    cyc_d        = (state_q == S_IDLE || tick) ? '0 : cyc_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    ready_d      = ready_q;
    sent_count_d = sent_count_q;
    armed_d      = uart_clock_enable ? armed_q : 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = uart_data;
          ready_d = 1'b0;
          tx_d    = 1'b0;
          bit_d   = '0;
          armed_d = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d  = shift_q[0];
          bit_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q != 3'd7) begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end else begin
            bit_d = '0;
            tx_d  = (PARITY != 0) ? parity_bit : 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d  = 1'b1;
          bit_d = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            ready_d      = 1'b1;
            sent_count_d = sent_count_q + 16'd1;
          end else begin
            bit_d = bit_nxt;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  assign uart_ready = ready_q;
  assign tx         = tx_q;
  assign sent_count = sent_count_q;

endmodule
